// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state, grant-owner encoding and default limits for mem_port_arbiter
package mem_arb_pkg;
    typedef enum logic [2:0] {IDLE, GRANT_IF, GRANT_DM, DONE_IF, DONE_DM} state_t;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int MAX_WAIT_DEF = 16;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates a single-port memory between instruction fetch (if_*) and data (dm_*) requesters
// Ports: clk/rst (async, active-high); if_req/if_addr -> if_rdata/if_ack; dm_req/dm_we/dm_addr/dm_wdata -> dm_rdata/dm_ack;
// memory side mem_req/mem_we/mem_addr/mem_wdata with mem_rdata/mem_ready; busy (not idle); err (sticky wait timeout).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int MAX_WAIT     = MAX_WAIT_DEF,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          err_q, err_d;
    logic          win, done;
    logic [DW-1:0] rd;

    // IF only overrides DM priority once it has lost STARVE_LIMIT arbitrations in a row
    assign win  = (dm_req && (!if_req || starve_q < STARVE_MAX)) ? OWN_DM : OWN_IF;
    assign done = mem_ready || wait_q == WAIT_LAST;
    // stores and timeouts return zero data
    assign rd   = (mem_ready && !we_q) ? mem_rdata : '0;

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: if (dm_req || if_req) begin
                state_d  = (win == OWN_DM) ? GRANT_DM : GRANT_IF;
                addr_d   = (win == OWN_DM) ? dm_addr : if_addr;
                we_d     = (win == OWN_DM) && dm_we;
                wdata_d  = (win == OWN_DM) ? dm_wdata : '0;
                wait_d   = '0;
                starve_d = (win == OWN_IF) ? '0 :
                           (if_req && starve_q != STARVE_MAX) ? starve_q + SW'(1) : starve_q;
            end
            GRANT_IF, GRANT_DM: begin
                wait_d     = done ? '0 : wait_q + WW'(1);
                err_d      = err_q || (!mem_ready && wait_q == WAIT_LAST);
                if_rdata_d = (done && state_q == GRANT_IF) ? rd : if_rdata_q;
                dm_rdata_d = (done && state_q == GRANT_DM) ? rd : dm_rdata_q;
                state_d    = !done ? state_q : (state_q == GRANT_IF) ? DONE_IF : DONE_DM;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            wait_q     <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            err_q      <= err_d;
        end
    end

    assign mem_req   = state_q == GRANT_IF || state_q == GRANT_DM;
    assign if_ack    = state_q == DONE_IF;
    assign dm_ack    = state_q == DONE_DM;
    assign busy      = state_q != IDLE;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign err       = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a wait-configurable memory model
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ack, dm_ack, mem_req, mem_we, busy, err;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int len; } mem_e;
    typedef struct { logic dm; logic [31:0] rdata; logic err; } ack_e;
    mem_e mq[$];
    ack_e aq[$];
    int checks = 0, failures = 0, acks = 0;
    int wait_cfg = 0, gcnt = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    // memory model: ready on grant cycle number wait_cfg (-1 = never)
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            mem_ready = (gcnt == wait_cfg);
            gcnt++;
        end else begin
            mem_ready = 1'b0;
            gcnt = 0;
        end
    end

    // monitor: compares memory-side accesses and acks against the scoreboard queues
    mem_e cur;
    int   len = 0;
    logic req_p = 1'b0, ack_p = 1'b0;
    always @(negedge clk) begin
        if (mem_req && !req_p) begin
            if (mq.size() == 0) begin
                checks++; failures++;
                $display("FAIL mem_unexpected actual=%h required=none", mem_addr);
            end else begin
                cur = mq.pop_front();
                chk("mem_we", 32'(mem_we), 32'(cur.we));
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_wdata", mem_wdata, cur.wdata);
            end
            len = 1;
        end else if (mem_req) begin
            len++;
            chk("mem_hold_we", 32'(mem_we), 32'(cur.we));
            chk("mem_hold_addr", mem_addr, cur.addr);
            chk("mem_hold_wdata", mem_wdata, cur.wdata);
        end else if (req_p) begin
            chk("mem_req_len", 32'(len), 32'(cur.len));
        end
        if (if_ack || dm_ack) begin
            ack_e e;
            acks++;
            chk("ack_pulse_width", 32'(ack_p), 32'd0);
            chk("ack_both", 32'(if_ack & dm_ack), 32'd0);
            if (aq.size() == 0) begin
                checks++; failures++;
                $display("FAIL ack_unexpected actual=if%0b_dm%0b required=none", if_ack, dm_ack);
            end else begin
                e = aq.pop_front();
                chk("ack_port", 32'(dm_ack), 32'(e.dm));
                chk("ack_rdata", dm_ack ? dm_rdata : if_rdata, e.rdata);
                chk("ack_err", 32'(err), 32'(e.err));
            end
        end
        req_p = mem_req;
        ack_p = if_ack | dm_ack;
    end

    task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] wd, input int l);
        mem_e m;
        m.we = we; m.addr = a; m.wdata = wd; m.len = l;
        mq.push_back(m);
    endtask

    task automatic push_ack(input logic dm, input logic [31:0] rd, input logic e);
        ack_e x;
        x.dm = dm; x.rdata = rd; x.err = e;
        aq.push_back(x);
    endtask

    // returns in the cycle after the target ack, ahead of the next arbitration edge
    task automatic wait_acks(input int n);
        int t = 0;
        while (acks < n && t < 200) begin
            @(posedge clk); #2;
            t++;
        end
        if (acks < n) begin
            checks++; failures++;
            $display("FAIL ack_timeout actual=%0d required=%0d", acks, n);
        end
    endtask

    initial begin
        @(negedge clk); @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acks", 32'({if_ack, dm_ack}), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
        rst = 1'b0;
        // single fetch, zero-wait memory
        @(posedge clk); #1;
        wait_cfg = 0; mem_rdata = 32'h8C22_0004;
        push_mem(1'b0, 32'h10, 32'h0, 1); push_ack(1'b0, 32'h8C22_0004, 1'b0);
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk); chk("t1_c0_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk); chk("t1_c1_mem_req", 32'(mem_req), 32'd1);
        @(negedge clk); chk("t1_c2_if_ack", 32'(if_ack), 32'd1);
        @(posedge clk); #1 if_req = 1'b0;
        @(negedge clk); chk("t1_c3_busy", 32'(busy), 32'd0);
        // store with two wait cycles
        @(posedge clk); #1;
        wait_cfg = 2; mem_rdata = 32'hDEAD_BEEF;
        push_mem(1'b1, 32'h40, 32'h5A, 3); push_ack(1'b1, 32'h0, 1'b0);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h5A;
        wait_acks(acks + 1);
        dm_req = 1'b0; dm_we = 1'b0; dm_wdata = 32'h0;
        // fetch request held across the ack yields a second access
        wait_cfg = 0; mem_rdata = 32'h2400_0001;
        repeat (2) begin
            push_mem(1'b0, 32'h20, 32'h0, 1); push_ack(1'b0, 32'h2400_0001, 1'b0);
        end
        if_req = 1'b1; if_addr = 32'h20;
        wait_acks(acks + 1);
        chk("b2b_idle_gap_busy", 32'(busy), 32'd0);
        wait_acks(acks + 1);
        if_req = 1'b0;
        // both held: fetch wins after four consecutive losses
        mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            logic own_dm;
            own_dm = !(i == 4 || i == 9);
            push_mem(1'b0, own_dm ? 32'h200 : 32'h100, 32'h0, 1);
            push_ack(own_dm, 32'h1234_5678, 1'b0);
        end
        if_req = 1'b1; if_addr = 32'h100; dm_req = 1'b1; dm_addr = 32'h200;
        wait_acks(acks + 10);
        if_req = 1'b0; dm_req = 1'b0;
        // timeout on a hung load, then err stays set through a good fetch
        chk("pre_timeout_err", 32'(err), 32'd0);
        wait_cfg = -1;
        push_mem(1'b0, 32'h80, 32'h0, 16); push_ack(1'b1, 32'h0, 1'b1);
        dm_req = 1'b1; dm_addr = 32'h80;
        wait_acks(acks + 1);
        dm_req = 1'b0;
        wait_cfg = 1; mem_rdata = 32'hCAFE_0001;
        push_mem(1'b0, 32'h44, 32'h0, 2); push_ack(1'b0, 32'hCAFE_0001, 1'b1);
        if_req = 1'b1; if_addr = 32'h44;
        wait_acks(acks + 1);
        if_req = 1'b0;
        chk("err_sticky", 32'(err), 32'd1);
        // asynchronous reset in the middle of a fetch
        wait_cfg = -1;
        push_mem(1'b0, 32'h60, 32'h0, 3);
        if_req = 1'b1; if_addr = 32'h60;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_if_ack", 32'(if_ack), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        if_req = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        wait_cfg = 0; mem_rdata = 32'h0BAD_F00D;
        push_mem(1'b0, 32'h64, 32'h0, 1); push_ack(1'b0, 32'h0BAD_F00D, 1'b0);
        if_req = 1'b1; if_addr = 32'h64;
        wait_acks(acks + 1);
        if_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("mem_queue_drained", 32'(mq.size()), 32'd0);
        chk("ack_queue_drained", 32'(aq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
